// File: rtl/window_cost_aggregator.sv
// window_cost_aggregator: reduces an N x N window of absolute differences to a
// single matching cost. A clamp register applies optional per-element truncation,
// then a registered binary adder tree sums the elements. A parallel valid chain
// tracks which outputs carry real windows. i_en freezes the whole pipeline.
module window_cost_aggregator #(
   parameter int N  = 5,
   parameter int DW = 8,
   parameter int OW = DW + $clog2(N*N)
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_en,
   input  logic                         i_valid,
   input  logic [N-1:0][N-1:0][DW-1:0]  i_diff,
   input  logic                         i_trunc_en,
   input  logic [DW-1:0]                i_trunc_thr,
   output logic                         o_valid,
   output logic [OW-1:0]                o_crl
);

   // Number of adder stages needed to fold N*N operands down to one.
   localparam int S = $clog2(N*N);

   // Operand count held by pipeline stage s: N*N at the clamp stage, then
   // halved (rounding up, so an odd leftover survives) at every adder stage.
   function automatic int stage_cnt(input int s);
      int c;
      c = N * N;
      for (int i = 0; i < s; i++) begin
         c = (c + 1) / 2;
      end
      return c;
   endfunction

   // Stage 0 is the clamp register; stages 1..S form the adder tree.
   // Each stage is one bit wider than the previous, so no sum can overflow.
   for (genvar s = 0; s <= S; s++) begin : g_stage
      localparam int W   = DW + s;
      localparam int CNT = stage_cnt(s);

      logic [W-1:0] op_d [CNT];
      logic [W-1:0] op_q [CNT];

      if (s == 0) begin : g_clamp
         // Truncate each element to the threshold when truncation is enabled
         // for this window; flatten [row][col] into row-major order.
         always_comb begin
            op_d = '{default: '0};
            for (int r = 0; r < N; r++) begin
               for (int c = 0; c < N; c++) begin
                  if (i_trunc_en && (i_diff[r][c] > i_trunc_thr)) begin
                     op_d[r*N + c] = i_trunc_thr;
                  end else begin
                     op_d[r*N + c] = i_diff[r][c];
                  end
               end
            end
         end
      end else begin : g_sum
         localparam int PREV = stage_cnt(s - 1);

         // Sum adjacent pairs of the previous stage; an odd last operand is
         // carried forward zero-extended.
         always_comb begin
            op_d = '{default: '0};
            for (int i = 0; i < PREV / 2; i++) begin
               op_d[i] = W'(g_stage[s-1].op_q[2*i]) + W'(g_stage[s-1].op_q[2*i + 1]);
            end
            if ((PREV % 2) == 1) begin
               op_d[CNT-1] = W'(g_stage[s-1].op_q[PREV-1]);
            end
         end
      end

      // Stage register: cleared by reset, advances only while enabled.
      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            op_q <= '{default: '0};
         end else if (i_en) begin
            op_q <= op_d;
         end
      end
   end

   logic [S:0] valid_d;
   logic [S:0] valid_q;

   // Valid chain shifts in lockstep with the data stages.
   always_comb begin
      valid_d = {valid_q[S-1:0], i_valid};
   end

   // Valid register: cleared by reset so in-flight windows are discarded.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         valid_q <= '0;
      end else if (i_en) begin
         valid_q <= valid_d;
      end
   end

   assign o_valid = valid_q[S];
   assign o_crl   = g_stage[S].op_q[0];

endmodule

// File: tb/tb_window_cost_aggregator.sv
// tb_window_cost_aggregator: drives directed and random windows into the
// aggregator and compares against a delay-line model of window sums.
module tb_window_cost_aggregator;

   localparam int N  = 5;
   localparam int DW = 8;
   localparam int OW = DW + $clog2(N*N);
   localparam int L  = $clog2(N*N) + 1;

   typedef logic [N-1:0][N-1:0][DW-1:0] win_t;

   logic           clk = 1'b0;
   logic           rst;
   logic           en;
   logic           valid;
   win_t           diff;
   logic           trunc_en;
   logic [DW-1:0]  thr;
   logic           o_valid;
   logic [OW-1:0]  o_crl;

   int  cmp_count  = 0;
   int  fail_count = 0;
   int  out_seen   = 0;
   bit  edge_en;
   bit  exp_v;
   int  exp_c;
   bit  model_v [L];
   int  model_c [L];

   window_cost_aggregator #(.N(N), .DW(DW)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_en        (en),
      .i_valid     (valid),
      .i_diff      (diff),
      .i_trunc_en  (trunc_en),
      .i_trunc_thr (thr),
      .o_valid     (o_valid),
      .o_crl       (o_crl)
   );

   // Free-running clock, 10 time-unit period.
   always #5 clk = ~clk;

   // Window cost straight from the definition: sum of (optionally) clamped elements.
   function automatic int ref_cost(input win_t d, input logic te, input logic [DW-1:0] t);
      int sum;
      int e;
      sum = 0;
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            e = int'(d[r][c]);
            if (te && (e > int'(t))) e = int'(t);
            sum += e;
         end
      end
      return sum;
   endfunction

   function automatic win_t fill(input int v);
      win_t d;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            d[r][c] = DW'(v);
      return d;
   endfunction

   function automatic win_t rand_win();
      win_t d;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            d[r][c] = DW'($urandom_range(0, 255));
      return d;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < L; i++) begin
         model_v[i] = 1'b0;
         model_c[i] = 0;
      end
      exp_v = 1'b0;
      exp_c = 0;
   endtask

   task automatic applyStimulus(input logic v, input win_t d, input logic te, input logic [DW-1:0] t);
      valid    = v;
      diff     = d;
      trunc_en = te;
      thr      = t;
   endtask

   // Advance one clock edge: the model accepts a window every enabled edge and
   // presents it L enabled edges later. Outputs are sampled 1 unit after the edge.
   task automatic tick();
      @(posedge clk);
      edge_en = en && !rst;
      if (rst) begin
         model_clear();
      end else if (en) begin
         for (int i = 0; i < L-1; i++) begin
            model_v[i] = model_v[i+1];
            model_c[i] = model_c[i+1];
         end
         model_v[L-1] = valid;
         model_c[L-1] = ref_cost(diff, trunc_en, thr);
      end
      exp_v = model_v[0];
      exp_c = model_c[0];
      #1;
      if (edge_en && o_valid) out_seen++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      en  = 1'b0;
      applyStimulus(1'b0, fill(0), 1'b0, '0);
      model_clear();
      #2;
      cmp_count++;
      if (o_valid !== 1'b0) begin
         fail_count++;
         $display("[TB] FAIL reset_valid: got %0b expected 0", o_valid);
      end
      cmp_count++;
      if (o_crl !== '0) begin
         fail_count++;
         $display("[TB] FAIL reset_crl: got %0d expected 0", o_crl);
      end
      tick();
      tick();
      rst = 1'b0;
      en  = 1'b1;
      for (int t = 0; t < 3; t++) begin
         tick();
         cmp_count++;
         if (o_valid !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL post_reset_valid: got %0b expected 0", o_valid);
         end
      end
   endtask

   task automatic test_single(input string name, input win_t d, input logic te,
                              input logic [DW-1:0] t_thr, input int const_exp);
      en = 1'b1;
      for (int t = 1; t <= L + 2; t++) begin
         if (t == 1) applyStimulus(1'b1, d, te, t_thr);
         else        applyStimulus(1'b0, fill(0), 1'b0, '0);
         tick();
         cmp_count++;
         if (o_valid !== exp_v) begin
            fail_count++;
            $display("[TB] FAIL %s valid t=%0d: got %0b expected %0b", name, t, o_valid, exp_v);
         end
         if (exp_v) begin
            cmp_count++;
            if (o_crl !== OW'(exp_c)) begin
               fail_count++;
               $display("[TB] FAIL %s crl_model: got %0d expected %0d", name, o_crl, exp_c);
            end
         end
         if (t == L) begin
            cmp_count++;
            if (o_valid !== 1'b1 || o_crl !== OW'(const_exp)) begin
               fail_count++;
               $display("[TB] FAIL %s latency_value: got valid=%0b crl=%0d expected valid=1 crl=%0d",
                        name, o_valid, o_crl, const_exp);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int k;
      int first_t;
      int last_t;
      k       = 0;
      first_t = -1;
      last_t  = -1;
      en      = 1'b1;
      for (int t = 1; t <= 10 + L + 2; t++) begin
         if (t <= 10) applyStimulus(1'b1, fill(t), 1'b0, '0);
         else         applyStimulus(1'b0, fill(0), 1'b0, '0);
         tick();
         cmp_count++;
         if (o_valid !== exp_v) begin
            fail_count++;
            $display("[TB] FAIL b2b valid t=%0d: got %0b expected %0b", t, o_valid, exp_v);
         end
         if (o_valid === 1'b1) begin
            k++;
            if (first_t < 0) first_t = t;
            last_t = t;
            cmp_count++;
            if (o_crl !== OW'(25 * k)) begin
               fail_count++;
               $display("[TB] FAIL b2b crl #%0d: got %0d expected %0d", k, o_crl, 25 * k);
            end
         end
      end
      cmp_count++;
      if (k !== 10 || first_t !== L || (last_t - first_t + 1) !== 10) begin
         fail_count++;
         $display("[TB] FAIL b2b run: got count=%0d first=%0d last=%0d expected 10/%0d/%0d",
                  k, first_t, last_t, L, L + 9);
      end
   endtask

   task automatic test_stall();
      int  win;
      int  first_t;
      bit  prev_v;
      logic [OW-1:0] prev_c;
      win      = 0;
      first_t  = -1;
      out_seen = 0;
      prev_v   = o_valid;
      prev_c   = o_crl;
      for (int t = 1; t <= 30; t++) begin
         en = !(t >= 4 && t <= 6);
         if (!en)          applyStimulus(1'($urandom_range(0, 1)), rand_win(), 1'($urandom_range(0, 1)), DW'($urandom));
         else if (win < 8) begin
            applyStimulus(1'b1, rand_win(), 1'($urandom_range(0, 1)), DW'($urandom));
            win++;
         end
         else              applyStimulus(1'b0, rand_win(), 1'b0, '0);
         tick();
         cmp_count++;
         if (o_valid !== exp_v) begin
            fail_count++;
            $display("[TB] FAIL stall valid t=%0d: got %0b expected %0b", t, o_valid, exp_v);
         end
         if (exp_v) begin
            cmp_count++;
            if (o_crl !== OW'(exp_c)) begin
               fail_count++;
               $display("[TB] FAIL stall crl t=%0d: got %0d expected %0d", t, o_crl, exp_c);
            end
         end
         if (!en) begin
            cmp_count++;
            if (o_valid !== prev_v || o_crl !== prev_c) begin
               fail_count++;
               $display("[TB] FAIL stall_freeze t=%0d: got %0b/%0d expected %0b/%0d",
                        t, o_valid, o_crl, prev_v, prev_c);
            end
         end
         if (o_valid === 1'b1 && first_t < 0) first_t = t;
         prev_v = o_valid;
         prev_c = o_crl;
      end
      en = 1'b1;
      cmp_count++;
      if (out_seen !== 8 || first_t !== L + 3) begin
         fail_count++;
         $display("[TB] FAIL stall_count: got windows=%0d first=%0d expected 8/%0d",
                  out_seen, first_t, L + 3);
      end
   endtask

   task automatic test_random();
      for (int t = 1; t <= 80; t++) begin
         en = ($urandom_range(0, 9) < 8);
         applyStimulus(1'($urandom_range(0, 1)), rand_win(), 1'($urandom_range(0, 1)), DW'($urandom));
         tick();
         cmp_count++;
         if (o_valid !== exp_v) begin
            fail_count++;
            $display("[TB] FAIL random valid t=%0d: got %0b expected %0b", t, o_valid, exp_v);
         end
         if (exp_v) begin
            cmp_count++;
            if (o_crl !== OW'(exp_c)) begin
               fail_count++;
               $display("[TB] FAIL random crl t=%0d: got %0d expected %0d", t, o_crl, exp_c);
            end
         end
      end
      en = 1'b1;
   endtask

   task automatic test_reset_midflight();
      en = 1'b1;
      for (int t = 1; t <= L; t++) begin
         applyStimulus(1'b1, fill(t + 2), 1'b0, '0);
         tick();
      end
      cmp_count++;
      if (o_valid !== 1'b1 || o_crl !== OW'(25 * 3)) begin
         fail_count++;
         $display("[TB] FAIL rst_pre: got %0b/%0d expected 1/%0d", o_valid, o_crl, 25 * 3);
      end
      #2;
      rst = 1'b1;
      model_clear();
      #1;
      cmp_count++;
      if (o_valid !== 1'b0 || o_crl !== '0) begin
         fail_count++;
         $display("[TB] FAIL rst_async: got %0b/%0d expected 0/0", o_valid, o_crl);
      end
      applyStimulus(1'b1, fill(9), 1'b0, '0);
      tick();
      rst = 1'b0;
      for (int t = 1; t <= L + 4; t++) begin
         if (t == 3) applyStimulus(1'b1, fill(7), 1'b1, DW'(5));
         else        applyStimulus(1'b0, fill(0), 1'b0, '0);
         tick();
         cmp_count++;
         if (o_valid !== ((t == L + 2) ? 1'b1 : 1'b0)) begin
            fail_count++;
            $display("[TB] FAIL rst_after valid t=%0d: got %0b expected %0b", t, o_valid, (t == L + 2));
         end
         if (t == L + 2) begin
            cmp_count++;
            if (o_crl !== OW'(125)) begin
               fail_count++;
               $display("[TB] FAIL rst_after crl: got %0d expected 125", o_crl);
            end
         end
      end
   endtask

   // Scenario sequence followed by the one summary line.
   initial begin
      win_t idx;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            idx[r][c] = DW'(r * N + c);

      test_reset();
      test_single("ones",      fill(1),   1'b0, '0,     25);
      test_single("max",       fill(255), 1'b0, '0,     6375);
      test_single("idx_trunc", idx,       1'b1, DW'(20), 290);
      test_single("idx_plain", idx,       1'b0, DW'(20), 300);
      test_back_to_back();
      test_stall();
      test_random();
      test_reset_midflight();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
      $finish;
   end

endmodule

// File: doc/window_cost_aggregator.md
# window_cost_aggregator

Pipelined, parametrised window matching-cost aggregator for the disparity calculation core. It reduces an N×N window of per-pixel absolute differences to one cost value per disparity candidate, with optional per-element truncation (truncated-AD cost). It adds a global pipeline enable for back-pressure from the downstream winner-take-all stage. It accepts one window per enabled cycle at full throughput, with a fixed latency that depends only on N.

## Interface
Parameters:
- N, 5, window side length; odd, 3..15.
- DW, 8, width of one difference element.
- OW, DW+$clog2(N*N), output cost width (derived; not overridden).

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_en  input  1  pipeline enable; low freezes every pipeline register, including valids.
- i_valid  input  1  i_diff / i_trunc_* carry a valid window this cycle.
- i_diff[N-1:0][N-1:0]  input  DW each  absolute differences, [row][col].
- i_trunc_en  input  1  apply truncation to this window.
- i_trunc_thr  input  DW  truncation threshold for this window.
- o_valid  output  1  o_crl holds a valid aggregated cost.
- o_crl  output  OW  aggregated window cost.

## Operation
- Stage 0 (clamp register):
  - Each element e' = (i_trunc_en && i_diff > i_trunc_thr) ? i_trunc_thr : i_diff.
  - i_trunc_en and i_trunc_thr are sampled per window, together with i_diff, and are never retained across windows.
- Stages 1..S, with S = $clog2(N*N) (registered binary adder tree):
  - Each stage sums adjacent pairs of the previous stage's operands in flat row-major order (index r*N+c).
  - An odd last operand passes through unchanged, zero-extended.
  - Operand width grows by 1 bit per stage.
  - Stage S holds exactly one operand, which drives o_crl.
- Arithmetic is unsigned throughout.
  - OW bits cannot overflow: max = N*N*(2^DW−1).
  - No saturation logic is required.
- Valid: a 1-bit shift chain of S+1 registers runs in parallel with the data; o_valid is its last bit.
- Data registers advance regardless of valid; a bubble carries don't-care data. A zero o_crl on bubbles is not required.
- i_en low:
  - All data and valid registers hold their value.
  - Inputs presented that cycle are ignored, regardless of i_valid.
  - o_valid/o_crl stay constant, and downstream must not count a held output twice.
- Reset (i_rst high, any time, including mid-stream):
  - Asynchronously clears all valid bits and all data registers to 0.
  - Every in-flight window is discarded.
  - The first i_valid accepted after deassertion is the first window to emerge.

## Timing
- Latency: L = S+1 enabled cycles from the i_valid sample edge to o_valid high.
  - N=3: L=5. N=5: L=6. N=7: L=7.
- Throughput: one window per enabled cycle; no bubbles inserted.
- Window accepted at edge k with i_en high throughout: o_valid=1 and o_crl valid in the cycle following edge k+L−1, held for exactly one cycle if i_en stays high.
- Stall cycles (i_en low) add exactly one cycle each to a window's latency; ordering is preserved.
- Reset values: o_valid=0, o_crl=0.
- o_valid and o_crl are driven directly from registers, with no combinational path from inputs.

## Test plan
- N=5, DW=8, single window, all elements 1, trunc off → after 6 cycles o_valid pulses 1 cycle, o_crl=25.
- N=5, all elements 255 → o_crl=6375 (13-bit, no wrap).
- N=5, element = row-major index 0..24, trunc on, thr=20 → o_crl=290. Same data, trunc off → o_crl=300.
- 10 back-to-back windows (each element = window number w) → o_valid high for 10 consecutive cycles, o_crl=25w in order.
- Stream with i_en low for 3 cycles mid-flight → outputs frozen during the stall; all values correct and in order; latency +3; no duplicate or lost windows when counting o_valid on i_en-high cycles.
- Assert i_rst for 1 cycle while 4 windows are in flight → o_valid=0 and o_crl=0 immediately (asynchronous), no stale window emerges, and the next window appears exactly L cycles after acceptance.
